// File: rtl/ascon_decrypt.sv
// ascon_decrypt: iterative ASCON-128 authenticated decryption, one permutation round per clock.
// Define ASCON_DECRYPT_DBG_EN to expose the state register and round counter as debug ports.
module ascon_decrypt #(
    parameter logic [63:0] IV        = 64'h80400c0600000000,
    parameter int          PA_ROUNDS = 12,
    parameter int          PB_ROUNDS = 6
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [63:0]  ad_i,
    input  logic [127:0] tag_i,
    input  logic [63:0]  ct_i,
    input  logic         ct_valid_i,
    input  logic         ct_last_i,
    output logic         ct_ready_o,
    output logic [63:0]  pt_o,
    output logic         pt_valid_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o
`ifdef ASCON_DECRYPT_DBG_EN
    ,
    output logic [319:0] dbg_state_o,
    output logic [3:0]   dbg_round_o
`endif
);
    localparam logic [3:0] R_LAST = 4'(PA_ROUNDS - 1);
    localparam logic [3:0] R_PB   = 4'(PA_ROUNDS - PB_ROUNDS);

    typedef enum logic [2:0] {IDLE, INIT, AD, WAIT_CT, DEC, FINAL, DONE} fsm_t;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // constant addition, bit-sliced S-box, linear diffusion; 15-r equals ~r in 4 bits
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, ~r, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0 ^ ror(x0, 19) ^ ror(x0, 28), x1 ^ ror(x1, 61) ^ ror(x1, 39),
                x2 ^ ror(x2, 1) ^ ror(x2, 6), x3 ^ ror(x3, 10) ^ ror(x3, 17),
                x4 ^ ror(x4, 7) ^ ror(x4, 41)};
    endfunction

    fsm_t           fsm_q, fsm_d;
    logic [319:0]   state_q, state_d, rnd_in, rnd_out;
    logic [3:0]     round_q, round_d;
    logic [127:0]   key_q, key_d, tag_q, tag_d;
    logic [63:0]    ad_q, ad_d, pt_q, pt_d;
    logic           last_q, last_d, pt_valid_q, pt_valid_d, tag_ok_q, tag_ok_d;
    logic           last_round;

    assign last_round = round_q == R_LAST;
    assign rnd_out    = ascon_round(rnd_in, round_q);

    // phase injections apply only to the first round of AD and FINAL
    always_comb begin
        rnd_in = state_q;
        if (fsm_q == AD && round_q == R_PB) rnd_in[319:256] = state_q[319:256] ^ ad_q;
        if (fsm_q == FINAL && round_q == 4'd0) rnd_in = state_q ^ {64'h8000000000000000, key_q, 128'd0};
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        round_d    = round_q;
        key_d      = key_q;
        tag_d      = tag_q;
        ad_d       = ad_q;
        last_d     = last_q;
        pt_d       = pt_q;
        pt_valid_d = 1'b0;
        tag_ok_d   = tag_ok_q;
        case (fsm_q)
            IDLE: if (start_i) begin
                fsm_d    = INIT;
                round_d  = 4'd0;
                state_d  = {IV, key_i, nonce_i};
                key_d    = key_i;
                ad_d     = ad_i;
                tag_d    = tag_i;
                tag_ok_d = 1'b0;
            end
            INIT: begin
                state_d = last_round ? rnd_out ^ {192'd0, key_q} : rnd_out;
                round_d = last_round ? R_PB : round_q + 4'd1;
                fsm_d   = last_round ? AD : INIT;
            end
            AD: begin
                state_d = rnd_out ^ {319'd0, last_round};
                round_d = last_round ? R_PB : round_q + 4'd1;
                fsm_d   = last_round ? WAIT_CT : AD;
            end
            WAIT_CT: if (ct_valid_i) begin
                pt_d                = state_q[319:256] ^ ct_i;
                pt_valid_d          = 1'b1;
                state_d[319:256]    = ct_i;
                last_d              = ct_last_i;
                round_d             = R_PB;
                fsm_d               = DEC;
            end
            DEC: begin
                state_d = rnd_out;
                round_d = !last_round ? round_q + 4'd1 : last_q ? 4'd0 : R_PB;
                fsm_d   = !last_round ? DEC : last_q ? FINAL : WAIT_CT;
            end
            FINAL: begin
                state_d  = rnd_out;
                round_d  = last_round ? 4'd0 : round_q + 4'd1;
                fsm_d    = last_round ? DONE : FINAL;
                tag_ok_d = last_round ? (rnd_out[127:0] ^ key_q) == tag_q : tag_ok_q;
            end
            DONE: begin
                fsm_d   = IDLE;
                round_d = 4'd0;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            round_q    <= '0;
            key_q      <= '0;
            tag_q      <= '0;
            ad_q       <= '0;
            last_q     <= 1'b0;
            pt_q       <= '0;
            pt_valid_q <= 1'b0;
            tag_ok_q   <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            round_q    <= round_d;
            key_q      <= key_d;
            tag_q      <= tag_d;
            ad_q       <= ad_d;
            last_q     <= last_d;
            pt_q       <= pt_d;
            pt_valid_q <= pt_valid_d;
            tag_ok_q   <= tag_ok_d;
        end
    end

    assign ct_ready_o = fsm_q == WAIT_CT;
    assign busy_o     = fsm_q != IDLE && fsm_q != DONE;
    assign done_o     = fsm_q == DONE;
    assign pt_o       = pt_q;
    assign pt_valid_o = pt_valid_q;
    assign tag_ok_o   = tag_ok_q;
`ifdef ASCON_DECRYPT_DBG_EN
    assign dbg_state_o = fsm_q == IDLE ? '0 : state_q;
    assign dbg_round_o = fsm_q == IDLE ? '0 : round_q;
`endif
endmodule

// File: tb/tb_ascon_decrypt.sv
// tb_ascon_decrypt: randomized checks of ascon_decrypt against an array-based ASCON-128 model.
// Build with ASCON_DECRYPT_DBG_EN to also check the debug ports.
module tb_ascon_decrypt;
    localparam logic [63:0]  IV      = 64'h80400c0600000000;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [63:0]  KAT_AD  = 64'h3031323334353637;
    localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                         5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                         5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                         5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    logic         clock_i = 1'b0, resetb_i = 1'b1, start_i = 1'b0;
    logic         ct_valid_i = 1'b0, ct_last_i = 1'b0;
    logic [127:0] key_i = '0, nonce_i = '0, tag_i = '0;
    logic [63:0]  ad_i = '0, ct_i = '0;
    logic         ct_ready_o, pt_valid_o, busy_o, done_o, tag_ok_o;
    logic [63:0]  pt_o;
`ifdef ASCON_DECRYPT_DBG_EN
    logic [319:0] dbg_state_o;
    logic [3:0]   dbg_round_o;
`endif

    int errors = 0, checks = 0, cyc = 0;
    logic [63:0]  mx [5];
    logic [63:0]  ct_q [$], exp_pt [$], got_pt [$];
    logic [127:0] exp_tag;

    ascon_decrypt dut (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .key_i(key_i),
        .nonce_i(nonce_i), .ad_i(ad_i), .tag_i(tag_i), .ct_i(ct_i), .ct_valid_i(ct_valid_i),
        .ct_last_i(ct_last_i), .ct_ready_o(ct_ready_o), .pt_o(pt_o), .pt_valid_o(pt_valid_o),
        .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o)
`ifdef ASCON_DECRYPT_DBG_EN
        , .dbg_state_o(dbg_state_o), .dbg_round_o(dbg_round_o)
`endif
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;
    always @(negedge clock_i) if (pt_valid_o) got_pt.push_back(pt_o);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // reference permutation: table-driven S-box on each bit column, rounds 12-nr..11
    task automatic perm(input int nr);
        logic [63:0] y [5];
        logic [4:0]  v;
        for (int r = 12 - nr; r < 12; r++) begin
            mx[2] ^= 64'(8'hf0 - 8'(r * 15));
            for (int b = 0; b < 64; b++) begin
                v = SBOX[{mx[0][b], mx[1][b], mx[2][b], mx[3][b], mx[4][b]}];
                for (int j = 0; j < 5; j++) y[j][b] = v[4 - j];
            end
            for (int j = 0; j < 5; j++) mx[j] = y[j] ^ rotr(y[j], ROT_A[j]) ^ rotr(y[j], ROT_B[j]);
        end
    endtask

    task automatic model(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad);
        mx = '{IV, k[127:64], k[63:0], n[127:64], n[63:0]};
        perm(12);
        mx[3] ^= k[127:64];
        mx[4] ^= k[63:0];
        mx[0] ^= ad;
        perm(6);
        mx[4] ^= 64'd1;
        exp_pt.delete();
        foreach (ct_q[i]) begin
            exp_pt.push_back(mx[0] ^ ct_q[i]);
            mx[0] = ct_q[i];
            perm(6);
        end
        mx[0] ^= 64'h8000000000000000;
        mx[1] ^= k[127:64];
        mx[2] ^= k[63:0];
        perm(12);
        exp_tag = {mx[3], mx[4]} ^ k;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // drives one full decryption; ct_valid_i is held high except for an optional gap
    task automatic do_op(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                         input int nblk, input bit fresh, input int gap_blk, input int gap_len,
                         input bit bad_tag, input bit poke, output int lat, output bit tok,
                         output int pt_bad, output bit ready_drop, output bit done2, output bit busy2);
        int t0, idx = 0, gap = 0, nb;
        if (fresh) begin
            ct_q.delete();
            for (int i = 0; i < nblk; i++) ct_q.push_back({$urandom, $urandom});
        end
        nb = ct_q.size();
        model(k, n, ad);
        got_pt.delete();
        @(negedge clock_i);
        key_i = k; nonce_i = n; ad_i = ad; tag_i = exp_tag ^ 128'(bad_tag);
        start_i = 1'b1;
        t0 = cyc;
        lat = -1; tok = 1'b0; ready_drop = 1'b0;
        for (int c = 0; c < 300 && lat < 0; c++) begin
            @(negedge clock_i);
            key_i = rand128(); nonce_i = rand128(); tag_i = rand128(); ad_i = {$urandom, $urandom};
            start_i = poke && (cyc - t0 == 3);
            if (done_o) begin
                lat = cyc - t0;
                tok = tag_ok_o;
                start_i = poke;
            end
            ct_valid_i = 1'b1; ct_last_i = 1'b0; ct_i = {$urandom, $urandom};
            if (idx < nb) begin
                if (idx == gap_blk && gap < gap_len) begin
                    ct_valid_i = 1'b0;
                    if (ct_ready_o) gap++;
                    else if (gap > 0) ready_drop = 1'b1;
                end else begin
                    ct_i = ct_q[idx];
                    ct_last_i = idx == nb - 1;
                    if (ct_ready_o) idx++;
                end
            end
        end
        @(negedge clock_i);
        start_i = 1'b0; ct_valid_i = 1'b0; ct_last_i = 1'b0;
        done2 = done_o; busy2 = busy_o;
        pt_bad = got_pt.size() == exp_pt.size() ? 0 : 100;
        foreach (exp_pt[i]) if (i < got_pt.size() && got_pt[i] !== exp_pt[i]) pt_bad++;
    endtask

    task automatic test_reset();
        #2 resetb_i = 1'b0;
        #1 checks++;
        if ({busy_o, done_o, pt_valid_o, tag_ok_o, ct_ready_o, pt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {busy_o, done_o, pt_valid_o, tag_ok_o, ct_ready_o, pt_o});
        end
`ifdef ASCON_DECRYPT_DBG_EN
        checks++;
        if ({dbg_state_o, dbg_round_o} !== '0) begin
            errors++;
            $display("FAIL reset_dbg: got %h want 0", {dbg_state_o, dbg_round_o});
        end
`endif
        @(negedge clock_i);
        @(negedge clock_i) resetb_i = 1'b1;
    endtask

    task automatic test_init_load();
        @(negedge clock_i);
        key_i = KAT_KEY; nonce_i = KAT_KEY; start_i = 1'b1;
        @(negedge clock_i) start_i = 1'b0;
`ifdef ASCON_DECRYPT_DBG_EN
        checks++;
        if (dbg_state_o !== 320'h80400c0600000000_0001020304050607_08090a0b0c0d0e0f_0001020304050607_08090a0b0c0d0e0f) begin
            errors++;
            $display("FAIL init_state: got %h", dbg_state_o);
        end
        checks++;
        if (dbg_round_o !== 4'd0) begin
            errors++;
            $display("FAIL init_round: got %0d want 0", dbg_round_o);
        end
`endif
        checks++;
        if ({busy_o, ct_ready_o, done_o} !== 3'b100) begin
            errors++;
            $display("FAIL init_flags: got %b want 100", {busy_o, ct_ready_o, done_o});
        end
        resetb_i = 1'b0;
        #1 checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL init_abort: busy got %b want 0", busy_o);
        end
        @(negedge clock_i) resetb_i = 1'b1;
    endtask

    task automatic test_kat();
        int lat, pb;
        bit tok, rd, d2, b2;
        do_op(KAT_KEY, KAT_KEY, KAT_AD, 1, 1'b1, -1, 0, 1'b0, 1'b0, lat, tok, pb, rd, d2, b2);
        checks++; if (lat != 38) begin errors++; $display("FAIL kat_latency: got %0d want 38", lat); end
        checks++; if (tok !== 1'b1) begin errors++; $display("FAIL kat_tag_ok: got %b want 1", tok); end
        checks++; if (pb != 0) begin errors++; $display("FAIL kat_pt: %0d bad blocks, want 0", pb); end
        checks++; if ({d2, b2} !== 2'b00) begin errors++; $display("FAIL kat_done_pulse: done/busy got %b want 00", {d2, b2}); end
`ifdef ASCON_DECRYPT_DBG_EN
        checks++;
        if ({dbg_state_o, dbg_round_o} !== '0) begin errors++; $display("FAIL kat_dbg_idle: got nonzero debug in IDLE"); end
`endif
    endtask

    task automatic test_bad_tag();
        int lat, pb;
        bit tok, rd, d2, b2;
        do_op(KAT_KEY, KAT_KEY, KAT_AD, 1, 1'b0, -1, 0, 1'b1, 1'b0, lat, tok, pb, rd, d2, b2);
        checks++; if (lat != 38) begin errors++; $display("FAIL badtag_latency: got %0d want 38", lat); end
        checks++; if (tok !== 1'b0) begin errors++; $display("FAIL badtag_tag_ok: got %b want 0", tok); end
        checks++; if (pb != 0) begin errors++; $display("FAIL badtag_pt: %0d bad blocks, want 0", pb); end
    endtask

    task automatic test_gap();
        int lat, pb;
        bit tok, rd, d2, b2;
        do_op(rand128(), rand128(), {$urandom, $urandom}, 3, 1'b1, 1, 5, 1'b0, 1'b0, lat, tok, pb, rd, d2, b2);
        checks++; if (lat != 57) begin errors++; $display("FAIL gap_latency: got %0d want 57", lat); end
        checks++; if (tok !== 1'b1) begin errors++; $display("FAIL gap_tag_ok: got %b want 1", tok); end
        checks++; if (pb != 0) begin errors++; $display("FAIL gap_pt: %0d bad blocks, want 0", pb); end
        checks++; if (rd !== 1'b0) begin errors++; $display("FAIL gap_ready: ready dropped %b want 0", rd); end
    endtask

    task automatic test_mid_reset();
        int t0, lat, pb;
        bit tok, rd, d2, b2;
        @(negedge clock_i);
        key_i = rand128(); nonce_i = rand128(); start_i = 1'b1;
        ct_valid_i = 1'b1; ct_last_i = 1'b1; ct_i = {$urandom, $urandom};
        t0 = cyc;
        @(negedge clock_i) start_i = 1'b0;
        while (cyc - t0 < 22) @(negedge clock_i);
`ifdef ASCON_DECRYPT_DBG_EN
        checks++;
        if (dbg_round_o !== 4'd8) begin errors++; $display("FAIL midrst_round: got %0d want 8", dbg_round_o); end
`endif
        resetb_i = 1'b0;
        #1 checks++;
        if ({busy_o, done_o, pt_valid_o, tag_ok_o, ct_ready_o, pt_o} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0", {busy_o, done_o, pt_valid_o, tag_ok_o, ct_ready_o, pt_o});
        end
        @(negedge clock_i);
        resetb_i = 1'b1; ct_valid_i = 1'b0; ct_last_i = 1'b0;
        do_op(KAT_KEY, KAT_KEY, KAT_AD, 1, 1'b1, -1, 0, 1'b0, 1'b0, lat, tok, pb, rd, d2, b2);
        checks++; if (lat != 38) begin errors++; $display("FAIL midrst_latency: got %0d want 38", lat); end
        checks++; if ({tok, pb == 0} !== 2'b11) begin errors++; $display("FAIL midrst_result: tag_ok %b, %0d bad blocks", tok, pb); end
    endtask

    task automatic test_ignored_start();
        int lat, pb;
        bit tok, rd, d2, b2;
        do_op(rand128(), rand128(), {$urandom, $urandom}, 2, 1'b1, -1, 0, 1'b0, 1'b1, lat, tok, pb, rd, d2, b2);
        checks++; if (lat != 45) begin errors++; $display("FAIL poke_latency: got %0d want 45", lat); end
        checks++; if ({tok, pb == 0} !== 2'b11) begin errors++; $display("FAIL poke_result: tag_ok %b, %0d bad blocks", tok, pb); end
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL poke_after_done: busy got %b want 0", b2); end
    endtask

    task automatic test_random();
        int lat, pb, nb;
        bit tok, rd, d2, b2, bt;
        for (int i = 0; i < 6; i++) begin
            nb = $urandom_range(1, 4);
            bt = 1'($urandom_range(0, 1));
            do_op(rand128(), rand128(), {$urandom, $urandom}, nb, 1'b1, -1, 0, bt, 1'b0, lat, tok, pb, rd, d2, b2);
            checks++; if (lat != 31 + 7 * nb) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, 31 + 7 * nb); end
            checks++; if (tok !== !bt) begin errors++; $display("FAIL rand%0d_tag_ok: got %b want %b", i, tok, !bt); end
            checks++; if (pb != 0) begin errors++; $display("FAIL rand%0d_pt: %0d bad blocks, want 0", i, pb); end
        end
    endtask

    initial begin
        test_reset();
        test_init_load();
        test_kat();
        test_bad_tag();
        test_gap();
        test_mid_reset();
        test_ignored_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ascon_decrypt.md
Name: ascon_decrypt

Overview:
- Iterative ASCON-128 authenticated-decryption engine; the decrypt-side counterpart of the team's ASCON-128 encryption path.
- Reuses the existing permutation round stack from ascon_pack: constant_addition, then substitution layer, then diffusion layer.
- Executes one round per clock. Streams 64-bit ciphertext blocks in and plaintext blocks out, then reports tag verification.

Parameters:
- IV, 64'h80400c0600000000, ASCON-128 initialization vector loaded into x0.
- PA_ROUNDS, 12, rounds for initialization and finalization; round_i runs 0..11.
- PB_ROUNDS, 6, rounds for data-phase permutations; round_i runs 6..11.

Ports:
- clock_i  in  1  system clock.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse in IDLE; samples key_i, nonce_i, ad_i, tag_i.
- key_i  in  128  secret key K.
- nonce_i  in  128  nonce N.
- ad_i  in  64  single associated-data block, already padded by the user.
- tag_i  in  128  received tag to verify.
- ct_i  in  64  ciphertext block; full 64-bit blocks only.
- ct_valid_i  in  1  ct_i valid.
- ct_last_i  in  1  marks the final ciphertext block.
- ct_ready_o  out  1  engine accepts ct_i this cycle.
- pt_o  out  64  plaintext block.
- pt_valid_o  out  1  one-cycle pulse, pt_o valid.
- busy_o  out  1  high in every state except IDLE and DONE.
- done_o  out  1  one-cycle completion pulse.
- tag_ok_o  out  1  tag comparison result; held until the next start.

Behaviour:
- Reset (async, resetb_i=0):
  - FSM goes to IDLE; state, round counter and all outputs are cleared to 0.
  - Applies mid-operation too; there is no resume.
- FSM states: IDLE, INIT, AD, WAIT_CT, DEC, FINAL, DONE.
- IDLE, on start_i:
  - Load state = {IV, K[127:64], K[63:0], N[127:64], N[63:0]}.
  - Latch K, ad_i and tag_i internally; clear tag_ok_o; go to INIT.
- INIT: 12 cycles, round_i 0..11. The last-round result is stored with x3^=K[127:64] and x4^=K[63:0]. Then go to AD.
- AD: 6 cycles, round_i 6..11.
  - The first round's input is taken with x0^=ad.
  - The last-round result is stored with x4^=64'h1 (domain separation).
  - Then go to WAIT_CT.
- WAIT_CT: ct_ready_o=1. On ct_valid_i:
  - Register pt_o = x0 ^ ct_i; pt_valid_o is high the next cycle.
  - Set x0 = ct_i, latch ct_last_i, go to DEC.
  - ct_valid_i outside WAIT_CT is ignored; ct_ready_o is 0 there.
- DEC: 6 rounds, round_i 6..11; then back to WAIT_CT, or to FINAL if the latched last flag is set.
- FINAL: 12 cycles, round_i 0..11.
  - The first round's input is taken with x0^=64'h8000000000000000 (padding block), x1^=K[127:64], x2^=K[63:0].
  - After the last round: tag = {x3, x4} ^ K; tag_ok_o = (tag == latched tag_i).
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Round input:
  - Each cycle's round input is the state register with the phase injection applied only on that phase's first round.
  - The 4-bit round counter never wraps beyond 11.
- Latency: with the start cycle as T0 and ct_valid_i held high, done_o rises at T0 + 31 + 7*N for N blocks (N=1 gives 38).
- Boundary conditions:
  - start_i while busy_o=1 is ignored.
  - start_i in the DONE cycle is ignored.
  - Plaintext is released before tag verification. Consumers must discard it if tag_ok_o=0.

Optional Feature:
- ASCON_DECRYPT_DBG_EN defined:
  - Adds output ports dbg_state_o (320 bits, the state register) and dbg_round_o (4 bits, the current round_i).
  - Both are zero in IDLE.
- Macro undefined: these ports do not exist. Functional behaviour is identical.

Test Plan:
- Reset then start with K=N=0x000102030405060708090A0B0C0D0E0F (debug on) -> in the first INIT cycle, dbg_state_o = {80400c0600000000, 0001020304050607, 08090a0b0c0d0e0f, 0001020304050607, 08090a0b0c0d0e0f}.
- KAT: same K/N, ad=0x3031323334353637, one ciphertext block plus tag from the team's Python golden model -> pt_o matches the model, tag_ok_o=1, done_o exactly 38 cycles after start.
- Same vector with tag_i bit 0 flipped -> pt_o unchanged, tag_ok_o=0, done_o pulse at cycle 38.
- Three blocks with ct_valid_i deasserted for 5 cycles before block 2 -> ct_ready_o stays high while waiting, plaintext matches the model, done_o at 31+21+5=57.
- resetb_i low during DEC round 8, then a new start -> all outputs 0 in reset; the second run completes the KAT correctly.
- start_i pulsed during INIT and during DONE -> ignored; the run's results are unchanged.
